pcl_unit: RTL and testbench
===========================

Name: pcl_unit

Overview:
- Program-counter low-byte stage of the 65c02 core. Sits directly upstream of the PC high-byte stage.
- Holds PCL and drives address bus low and data bus with it.
- Performs increment, data-bus load and vector-low load.
- On FF->00 wrap, runs a four-phase carry handshake (carry_to_pch / carry_done) with the high-byte stage and stalls further increments until it completes.

Parameters:
- RESET_PCL, 8'h00, PCL value after reset.
- VEC_BASE, 8'hFA, low byte of the lowest hardware vector (NMI). RESET and IRQ vectors are VEC_BASE+2 and VEC_BASE+4.

Ports:
- fclk  in  1  core clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pcl_load  in  1  load PCL from db_in.
- vector_load  in  1  load PCL with selected vector low byte.
- vector_sel  in  2  00 NMI, 01 RESET, 10 IRQ/BRK, 11 treated as IRQ/BRK.
- pc_inc  in  1  increment request.
- db_in  in  8  internal data bus.
- db_out  out  8  PCL onto data bus (push of PCL).
- address_low_out  out  8  PCL onto address bus low.
- carry_to_pch  out  1  carry request to high-byte stage.
- carry_done  in  1  acknowledge from high-byte stage.
- pcl_busy  out  1  handshake in progress; sequencer must not issue pc_inc.
- branch_take  in  1  (BRANCH_REL_EN only) add branch_offset to PCL.
- branch_offset  in  8  (BRANCH_REL_EN only) signed two's-complement offset.
- borrow_to_pch  out  1  (BRANCH_REL_EN only) decrement request to high-byte stage.

Behaviour:
- Reset (async, reset_n=0): PCL=RESET_PCL, FSM=IDLE, carry_to_pch=0, borrow_to_pch=0, pcl_busy=0. db_out and address_low_out follow PCL.
- db_out and address_low_out are combinational from the PCL register; zero added latency.
- Update priority per edge: pcl_load > vector_load > branch_take > pc_inc.
  - pcl_load: PCL<=db_in.
  - vector_load: PCL<=VEC_BASE+2*sel (sel 11 -> VEC_BASE+4).
  - pc_inc: PCL<=PCL+1, 8-bit wrap.
- Loads are accepted in any FSM state. They change PCL only; a handshake already in progress runs to completion unaffected.
- pc_inc while pcl_busy=1 is ignored: PCL unchanged, no new request.
- Carry FSM:
  - IDLE: pcl_busy=0. An accepted pc_inc with PCL==FF sets PCL<=00 and goes to REQ.
  - REQ: carry_to_pch=1, pcl_busy=1. Stay until carry_done=1 is sampled, then go to ACK.
  - ACK: carry_to_pch=0, pcl_busy=1. Stay until carry_done=0 is sampled, then go to IDLE.
- Minimum handshake length is 2 cycles (REQ + ACK) when the acknowledge follows on the next edge.
- carry_to_pch is registered (a state decode of REQ) and glitch-free.
- Wrap and a simultaneous load: a load has priority, so the increment is not performed and no handshake starts.
- Reset asserted mid-handshake: immediate return to IDLE with carry_to_pch=0.

Optional Feature:
- Macro: PCL_BRANCH_REL_EN.
- Defined:
  - branch_take adds sign-extended branch_offset to PCL (8-bit result).
  - Unsigned carry out with offset>=0 starts the carry handshake through REQ.
  - Borrow with offset<0 starts the same handshake using borrow_to_pch in place of carry_to_pch (REQ_B / ACK_B states).
  - branch_take while pcl_busy=1 is ignored.
- Not defined:
  - branch_take, branch_offset and borrow_to_pch are absent.
  - The FSM has only IDLE/REQ/ACK.
  - Functionally identical otherwise.

Test Plan:
- Reset, then pc_inc x3 -> address_low_out 00,01,02,03; carry_to_pch stays 0.
- pcl_load db_in=FE; pc_inc x2 -> PCL FF then 00. carry_to_pch rises on the edge producing 00. With carry_done tied high one cycle later: carry_to_pch falls, then carry_done=0 returns FSM to IDLE; pcl_busy high exactly 2 cycles.
- PCL=FF in REQ, carry_done held 0 for 5 cycles with pc_inc pulsed -> PCL stays 00, carry_to_pch and pcl_busy stay 1 throughout.
- vector_load with sel=00/01/10/11 -> PCL FA/FC/FE/FE. Same cycle pcl_load db_in=55 -> PCL=55 (load wins).
- reset_n pulsed low mid-REQ between clock edges -> carry_to_pch and pcl_busy drop immediately, PCL=RESET_PCL.
- (PCL_BRANCH_REL_EN) PCL=F0, offset=+20 -> PCL=10, carry_to_pch handshake. PCL=05, offset=-10 (F6) -> PCL=FB, borrow_to_pch handshake. PCL=40, offset=+10 -> PCL=50, no request.

Source files
------------

// File: rtl/pcl_unit.sv
// Program-counter low byte for the 65c02 core: increment, loads and the carry/borrow handshake.
// Optional relative-branch adder enabled by defining PCL_BRANCH_REL_EN.
module pcl_unit #(
  parameter logic [7:0] RESET_PCL = 8'h00,
  parameter logic [7:0] VEC_BASE  = 8'hFA
) (
  input  logic       fclk,
  input  logic       reset_n,
  input  logic       pcl_load,
  input  logic       vector_load,
  input  logic [1:0] vector_sel,
  input  logic       pc_inc,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic [7:0] address_low_out,
  output logic       carry_to_pch,
  input  logic       carry_done,
`ifdef PCL_BRANCH_REL_EN
  input  logic       branch_take,
  input  logic [7:0] branch_offset,
  output logic       borrow_to_pch,
`endif
  output logic       pcl_busy
);

`ifdef PCL_BRANCH_REL_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK   = 3'd2,
    ST_REQ_B = 3'd3,
    ST_ACK_B = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] pcl_q, pcl_d;
  logic       carry_q, busy_q;
  logic       start_carry_s;
`ifdef PCL_BRANCH_REL_EN
  logic       borrow_q;
  logic       start_borrow_s;
  logic [8:0] sum_s;
`endif

  // Reserved encoding 11 aliases the IRQ/BRK vector.
  function automatic logic [7:0] vec_lo(input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      2'b00:   v = VEC_BASE;
      2'b01:   v = VEC_BASE + 8'h02;
      default: v = VEC_BASE + 8'h04;
    endcase
    return v;
  endfunction

  // PCL update with load > vector > branch > increment priority.
  always_comb begin
    pcl_d         = pcl_q;
    start_carry_s = 1'b0;
`ifdef PCL_BRANCH_REL_EN
    start_borrow_s = 1'b0;
    sum_s          = 9'h000;
`endif
    if (pcl_load) begin
      pcl_d = db_in;
    end else if (vector_load) begin
      pcl_d = vec_lo(vector_sel);
`ifdef PCL_BRANCH_REL_EN
    end else if (branch_take && !busy_q) begin
      // Negative offsets borrow exactly when the unsigned add produces no carry.
      sum_s = {1'b0, pcl_q} + {1'b0, branch_offset};
      pcl_d = sum_s[7:0];
      if (branch_offset[7]) begin
        start_borrow_s = ~sum_s[8];
      end else begin
        start_carry_s = sum_s[8];
      end
`endif
    end else if (pc_inc && !busy_q) begin
      pcl_d         = pcl_q + 8'h01;
      start_carry_s = (pcl_q == 8'hFF);
    end else begin
      pcl_d = pcl_q;
    end
  end

  // Four-phase handshake sequencing; loads never disturb it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_carry_s) begin
          state_d = ST_REQ;
`ifdef PCL_BRANCH_REL_EN
        end else if (start_borrow_s) begin
          state_d = ST_REQ_B;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (carry_done) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_ACK: begin
        if (!carry_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
`ifdef PCL_BRANCH_REL_EN
      ST_REQ_B: begin
        if (carry_done) begin
          state_d = ST_ACK_B;
        end else begin
          state_d = ST_REQ_B;
        end
      end
      ST_ACK_B: begin
        if (!carry_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK_B;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PCL and registered handshake outputs.
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      pcl_q    <= RESET_PCL;
      state_q  <= ST_IDLE;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PCL_BRANCH_REL_EN
      borrow_q <= 1'b0;
`endif
    end else begin
      pcl_q    <= pcl_d;
      state_q  <= state_d;
      carry_q  <= (state_d == ST_REQ);
      busy_q   <= (state_d != ST_IDLE);
`ifdef PCL_BRANCH_REL_EN
      borrow_q <= (state_d == ST_REQ_B);
`endif
    end
  end

  assign db_out          = pcl_q;
  assign address_low_out = pcl_q;
  assign carry_to_pch    = carry_q;
  assign pcl_busy        = busy_q;
`ifdef PCL_BRANCH_REL_EN
  assign borrow_to_pch   = borrow_q;
`endif

endmodule

// File: tb/tb_pcl_unit.sv
// Self-checking bench for pcl_unit: directed vector table, corner sequences and a randomized model run.
module tb_pcl_unit;
  localparam logic [7:0] RESET_PCL = 8'h00;
  localparam logic [7:0] VEC_BASE  = 8'hFA;

  logic       fclk = 1'b0;
  logic       reset_n;
  logic       pcl_load, vector_load, pc_inc, carry_done;
  logic [1:0] vector_sel;
  logic [7:0] db_in;
  logic [7:0] db_out, address_low_out;
  logic       carry_to_pch, pcl_busy;
`ifdef PCL_BRANCH_REL_EN
  logic       branch_take;
  logic [7:0] branch_offset;
  logic       borrow_to_pch;
`endif

  int checks = 0;
  int errors = 0;

  pcl_unit #(.RESET_PCL(RESET_PCL), .VEC_BASE(VEC_BASE)) dut (
    .fclk(fclk), .reset_n(reset_n), .pcl_load(pcl_load), .vector_load(vector_load),
    .vector_sel(vector_sel), .pc_inc(pc_inc), .db_in(db_in), .db_out(db_out),
    .address_low_out(address_low_out), .carry_to_pch(carry_to_pch),
    .carry_done(carry_done),
`ifdef PCL_BRANCH_REL_EN
    .branch_take(branch_take), .branch_offset(branch_offset), .borrow_to_pch(borrow_to_pch),
`endif
    .pcl_busy(pcl_busy)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic       ld;
    logic       vl;
    logic [1:0] sel;
    logic       inc;
    logic [7:0] db;
    logic       cd;
    logic [7:0] pcl;
    logic       c;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: PCL as an integer plus a handshake described by what it awaits.
  int m_pcl;
  bit m_active, m_wait_high, m_is_borrow;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic idle_inputs();
    pcl_load = 1'b0; vector_load = 1'b0; vector_sel = 2'b00; pc_inc = 1'b0;
    db_in = 8'h00; carry_done = 1'b0;
`ifdef PCL_BRANCH_REL_EN
    branch_take = 1'b0; branch_offset = 8'h00;
`endif
  endtask

  task automatic add(input logic ld, input logic vl, input logic [1:0] sel, input logic inc,
                     input logic [7:0] db, input logic cd, input logic [7:0] pcl,
                     input logic c, input logic b);
    vec_t v;
    v.ld = ld; v.vl = vl; v.sel = sel; v.inc = inc; v.db = db; v.cd = cd;
    v.pcl = pcl; v.c = c; v.b = b;
    vecs.push_back(v);
  endtask

  task automatic model_step();
    int  s;
    int  k;
    bit  start_c, start_b;
    start_c = 1'b0; start_b = 1'b0;
    if (pcl_load) begin
      m_pcl = int'(db_in);
    end else if (vector_load) begin
      k = (vector_sel > 2'd2) ? 2 : int'(vector_sel);
      m_pcl = (int'(VEC_BASE) + 2 * k) % 256;
`ifdef PCL_BRANCH_REL_EN
    end else if (branch_take && !m_active) begin
      s = m_pcl + int'($signed(branch_offset));
      start_c = (s > 255);
      start_b = (s < 0);
      m_pcl = (s + 256) % 256;
`endif
    end else if (pc_inc && !m_active) begin
      s = m_pcl + 1;
      start_c = (s > 255);
      m_pcl = s % 256;
    end
    if (m_active) begin
      if (m_wait_high && carry_done) m_wait_high = 1'b0;
      else if (!m_wait_high && !carry_done) m_active = 1'b0;
    end else if (start_c || start_b) begin
      m_active = 1'b1; m_wait_high = 1'b1; m_is_borrow = start_b;
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, " addr"}, address_low_out, m_pcl[7:0]);
    chk({tag, " db_out"}, db_out, m_pcl[7:0]);
    chk({tag, " carry"}, {7'b0, carry_to_pch}, {7'b0, m_active && m_wait_high && !m_is_borrow});
    chk({tag, " busy"}, {7'b0, pcl_busy}, {7'b0, m_active});
`ifdef PCL_BRANCH_REL_EN
    chk({tag, " borrow"}, {7'b0, borrow_to_pch}, {7'b0, m_active && m_wait_high && m_is_borrow});
`endif
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) tick();
    chk("reset addr", address_low_out, RESET_PCL);
    chk("reset db_out", db_out, RESET_PCL);
    chk("reset carry", {7'b0, carry_to_pch}, 8'h00);
    chk("reset busy", {7'b0, pcl_busy}, 8'h00);
    @(negedge fclk);
    reset_n = 1'b1;

    //  ld    vl    sel    inc   db     cd    pcl    c     b
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 1'b0, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFA, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 8'hFC, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0);
    add(1'b1, 1'b1, 2'd1, 1'b0, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 1'b0, 8'h33, 1'b0, 8'h33, 1'b1, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 8'h34, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      pcl_load = vecs[i].ld; vector_load = vecs[i].vl; vector_sel = vecs[i].sel;
      pc_inc = vecs[i].inc; db_in = vecs[i].db; carry_done = vecs[i].cd;
      tick();
      chk($sformatf("vec%0d pcl", i), address_low_out, vecs[i].pcl);
      chk($sformatf("vec%0d db_out", i), db_out, vecs[i].pcl);
      chk($sformatf("vec%0d carry", i), {7'b0, carry_to_pch}, {7'b0, vecs[i].c});
      chk($sformatf("vec%0d busy", i), {7'b0, pcl_busy}, {7'b0, vecs[i].b});
    end

    // Asynchronous reset in the middle of a carry request.
    idle_inputs();
    pcl_load = 1'b1; db_in = 8'hFF;
    tick();
    idle_inputs();
    pc_inc = 1'b1;
    tick();
    idle_inputs();
    chk("pre-reset carry", {7'b0, carry_to_pch}, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset carry", {7'b0, carry_to_pch}, 8'h00);
    chk("async reset busy", {7'b0, pcl_busy}, 8'h00);
    chk("async reset pcl", address_low_out, RESET_PCL);
    @(negedge fclk);
    reset_n = 1'b1;

`ifdef PCL_BRANCH_REL_EN
    pcl_load = 1'b1; db_in = 8'hF0; tick(); idle_inputs();
    branch_take = 1'b1; branch_offset = 8'h20; tick(); idle_inputs();
    chk("br fwd pcl", address_low_out, 8'h10);
    chk("br fwd carry", {7'b0, carry_to_pch}, 8'h01);
    chk("br fwd borrow", {7'b0, borrow_to_pch}, 8'h00);
    carry_done = 1'b1; tick(); carry_done = 1'b0; tick();
    chk("br fwd done busy", {7'b0, pcl_busy}, 8'h00);
    pcl_load = 1'b1; db_in = 8'h05; tick(); idle_inputs();
    branch_take = 1'b1; branch_offset = 8'hF6; tick(); idle_inputs();
    chk("br back pcl", address_low_out, 8'hFB);
    chk("br back borrow", {7'b0, borrow_to_pch}, 8'h01);
    chk("br back carry", {7'b0, carry_to_pch}, 8'h00);
    carry_done = 1'b1; tick();
    chk("br back ack borrow", {7'b0, borrow_to_pch}, 8'h00);
    chk("br back ack busy", {7'b0, pcl_busy}, 8'h01);
    carry_done = 1'b0; tick();
    chk("br back done busy", {7'b0, pcl_busy}, 8'h00);
    pcl_load = 1'b1; db_in = 8'h40; tick(); idle_inputs();
    branch_take = 1'b1; branch_offset = 8'h10; tick(); idle_inputs();
    chk("br plain pcl", address_low_out, 8'h50);
    chk("br plain busy", {7'b0, pcl_busy}, 8'h00);
`endif

    // Randomized run against the model, starting from a fresh reset.
    idle_inputs();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    m_pcl = int'(RESET_PCL); m_active = 1'b0; m_wait_high = 1'b0; m_is_borrow = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      pcl_load    = ($urandom_range(0, 11) == 0);
      vector_load = ($urandom_range(0, 11) == 0);
      vector_sel  = 2'($urandom_range(0, 3));
      pc_inc      = ($urandom_range(0, 1) == 1);
      db_in       = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hFC, 8'hFF))
                                                : 8'($urandom_range(0, 255));
      carry_done  = ($urandom_range(0, 2) == 0);
`ifdef PCL_BRANCH_REL_EN
      branch_take   = ($urandom_range(0, 4) == 0);
      branch_offset = 8'($urandom_range(0, 255));
`endif
      model_step();
      tick();
      model_compare($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
